// File: rtl/ram_responder_pkg.sv
// Shared constants for the mobo RAM interface: control/status bit indices,
// responder FSM state encoding and the bad-address read pattern.
package ram_responder_pkg;

  // Bit positions in ram_ctrl_from_mobo
  localparam int unsigned RamReadPin   = 0;
  localparam int unsigned RamWritePin  = 1;

  // Bit positions in ram_ctrl_to_mobo
  localparam int unsigned RamReadDone  = 0;
  localparam int unsigned RamWriteDone = 1;
  localparam int unsigned RamError     = 2;
  localparam int unsigned RamBusy      = 3;

  localparam logic [31:0] RamBadAddrData = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    RStateIdle = 2'd0,
    RStateBusy = 2'd1,
    RStateDone = 2'd2
  } r_state_e;

endpackage

// File: rtl/ram_storage_array.sv
// Word-addressed 32-bit storage: synchronous write, combinational read of the
// same (captured) index. Contents survive reset.
module ram_storage_array #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] idx_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [31:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/ram_responder.sv
// Memory-side endpoint of the mobo RAM request/done handshake with fixed LATENCY.
// Optional RAM_RESPONDER_BOUNDS_CHECK_EN flags accesses with nonzero upper address bits.
module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ram_ctrl_from_mobo_i,
  output logic [31:0] ram_ctrl_to_mobo_o,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_from_mobo_i,
  output logic [31:0] data_to_mobo_o
);

  // Counter starts at LATENCY-1 so the access lands exactly LATENCY edges after sampling.
  localparam logic [3:0] LatLoad = 4'(LATENCY - 1);

  r_state_e          state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_op_q, wr_op_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              bad_q, bad_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rd_done_q, rd_done_d;
  logic              wr_done_q, wr_done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic              rd_req, wr_req, held_req;
  logic              mem_we;
  logic [31:0]       mem_rdata;
  logic              addr_hi_bad;

  assign rd_req   = ram_ctrl_from_mobo_i[RamReadPin];
  assign wr_req   = ram_ctrl_from_mobo_i[RamWritePin];
  assign held_req = wr_op_q ? wr_req : rd_req;

`ifdef RAM_RESPONDER_BOUNDS_CHECK_EN
  assign addr_hi_bad = (addr_i[31:ADDR_W] != '0);
  logic unused_ctrl;
  assign unused_ctrl = ^ram_ctrl_from_mobo_i[31:2];
`else
  assign addr_hi_bad = 1'b0;
  logic unused_in;
  assign unused_in = ^{ram_ctrl_from_mobo_i[31:2], addr_i[31:ADDR_W]};
`endif

  ram_storage_array #(
    .ADDR_W (ADDR_W)
  ) u_storage (
    .clk     (clk),
    .we_i    (mem_we),
    .idx_i   (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_op_d   = wr_op_q;
    idx_d     = idx_q;
    bad_d     = bad_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    rd_done_d = rd_done_q;
    wr_done_d = wr_done_q;
    err_d     = err_q;
    mem_we    = 1'b0;

    unique case (state_q)
      RStateIdle: begin
        if (rd_req || wr_req) begin
          wr_op_d = wr_req;  // write wins when both are raised
          idx_d   = addr_i[ADDR_W-1:0];
          bad_d   = addr_hi_bad;
          wdata_d = data_from_mobo_i;
          cnt_d   = LatLoad;
          state_d = RStateBusy;
        end
      end
      RStateBusy: begin
        if (cnt_q == 4'd0) begin
          state_d = RStateDone;
          err_d   = bad_q;
          if (wr_op_q) begin
            mem_we    = !bad_q;
            wr_done_d = 1'b1;
          end else begin
            rd_done_d = 1'b1;
            rdata_d   = bad_q ? RamBadAddrData : mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RStateDone: begin
        if (!held_req) begin
          state_d   = RStateIdle;
          rd_done_d = 1'b0;
          wr_done_d = 1'b0;
          err_d     = 1'b0;
          rdata_d   = '0;
        end
      end
      default: state_d = RStateIdle;
    endcase

    busy_d = (state_d != RStateIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RStateIdle;
      cnt_q     <= '0;
      wr_op_q   <= 1'b0;
      idx_q     <= '0;
      bad_q     <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rd_done_q <= 1'b0;
      wr_done_q <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_op_q   <= wr_op_d;
      idx_q     <= idx_d;
      bad_q     <= bad_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      rd_done_q <= rd_done_d;
      wr_done_q <= wr_done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    ram_ctrl_to_mobo_o               = '0;
    ram_ctrl_to_mobo_o[RamReadDone]  = rd_done_q;
    ram_ctrl_to_mobo_o[RamWriteDone] = wr_done_q;
    ram_ctrl_to_mobo_o[RamError]     = err_q;
    ram_ctrl_to_mobo_o[RamBusy]      = busy_q;
  end

  assign data_to_mobo_o = rdata_q;

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder at LATENCY 2, 1 and 7; honours
// RAM_RESPONDER_BOUNDS_CHECK_EN for the wrap/bounds scenario.
module tb_ram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ctrl_in  [3];
  logic [31:0] addr_in  [3];
  logic [31:0] din      [3];
  logic [31:0] ctrl_out [3];
  logic [31:0] dout     [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ram_responder #(.ADDR_W(10), .LATENCY(2)) u_dut_l2 (
    .clk(clk), .rst(rst),
    .ram_ctrl_from_mobo_i(ctrl_in[0]), .ram_ctrl_to_mobo_o(ctrl_out[0]),
    .addr_i(addr_in[0]), .data_from_mobo_i(din[0]), .data_to_mobo_o(dout[0])
  );

  ram_responder #(.ADDR_W(10), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst),
    .ram_ctrl_from_mobo_i(ctrl_in[1]), .ram_ctrl_to_mobo_o(ctrl_out[1]),
    .addr_i(addr_in[1]), .data_from_mobo_i(din[1]), .data_to_mobo_o(dout[1])
  );

  ram_responder #(.ADDR_W(10), .LATENCY(7)) u_dut_l7 (
    .clk(clk), .rst(rst),
    .ram_ctrl_from_mobo_i(ctrl_in[2]), .ram_ctrl_to_mobo_o(ctrl_out[2]),
    .addr_i(addr_in[2]), .data_from_mobo_i(din[2]), .data_to_mobo_o(dout[2])
  );

  // Drives a request at a negedge and waits for a done bit. lat counts edges
  // from the sampling edge to the edge where done rose (-1 on timeout).
  task automatic run_req(input int d, input logic [31:0] ctrl, input logic [31:0] a,
                         input logic [31:0] wd, output int lat, output logic [31:0] st,
                         output logic [31:0] rd, output bit busy_ok);
    @(negedge clk);
    ctrl_in[d] = ctrl;
    addr_in[d] = a;
    din[d]     = wd;
    lat        = -1;
    busy_ok    = 1'b1;
    st         = '0;
    rd         = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      st = ctrl_out[d];
      rd = dout[d];
      if (st[1:0] != 2'b00) begin
        lat = k - 1;
        break;
      end
      if (!st[3]) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ctrl_in[i] = '0;
      addr_in[i] = '0;
      din[i]     = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ctrl_out[i] !== 32'h0 || dout[i] !== 32'h0) begin
        errors++;
        $display("FAIL reset_state dut%0d: ctrl=%h data=%h, want 0/0", i, ctrl_out[i], dout[i]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] st, rd; bit bok;
    run_req(0, 32'h2, 32'd5, 32'h1234_5678, lat, st, rd, bok);
    checks++;
    if (lat !== 2 || st !== 32'hA) begin
      errors++;
      $display("FAIL wr_latency2: lat=%0d ctrl=%h, want 2/0000000a", lat, st);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (ctrl_out[0] !== 32'hA) begin
      errors++;
      $display("FAIL wr_hold: ctrl=%h, want 0000000a", ctrl_out[0]);
    end
    ctrl_in[0] = '0;
    @(negedge clk);
    checks++;
    if (ctrl_out[0] !== 32'h0) begin
      errors++;
      $display("FAIL wr_release: ctrl=%h, want 0", ctrl_out[0]);
    end
    run_req(0, 32'h1, 32'd5, 32'h0, lat, st, rd, bok);
    checks++;
    if (lat !== 2 || st !== 32'h9 || rd !== 32'h1234_5678) begin
      errors++;
      $display("FAIL rd_addr5: lat=%0d ctrl=%h data=%h, want 2/00000009/12345678", lat, st, rd);
    end
    @(negedge clk);
    checks++;
    if (dout[0] !== 32'h1234_5678 || ctrl_out[0] !== 32'h9) begin
      errors++;
      $display("FAIL rd_hold: ctrl=%h data=%h, want 00000009/12345678", ctrl_out[0], dout[0]);
    end
    ctrl_in[0] = '0;
    @(negedge clk);
    checks++;
    if (ctrl_out[0] !== 32'h0 || dout[0] !== 32'h0) begin
      errors++;
      $display("FAIL rd_release: ctrl=%h data=%h, want 0/0", ctrl_out[0], dout[0]);
    end
  endtask

  task automatic test_latency();
    int lat; logic [31:0] st, rd; bit bok;
    run_req(1, 32'h2, 32'd1, 32'h11, lat, st, rd, bok);
    checks++;
    if (lat !== 1 || st !== 32'hA || !bok) begin
      errors++;
      $display("FAIL lat1_write: lat=%0d ctrl=%h busy_ok=%0d, want 1/0000000a/1", lat, st, bok);
    end
    ctrl_in[1] = '0;
    @(negedge clk);
    checks++;
    if (ctrl_out[1] !== 32'h0) begin
      errors++;
      $display("FAIL lat1_release: ctrl=%h, want 0", ctrl_out[1]);
    end
    run_req(2, 32'h2, 32'd1, 32'h22, lat, st, rd, bok);
    checks++;
    if (lat !== 7 || st !== 32'hA || !bok) begin
      errors++;
      $display("FAIL lat7_write: lat=%0d ctrl=%h busy_ok=%0d, want 7/0000000a/1", lat, st, bok);
    end
    ctrl_in[2] = '0;
    @(negedge clk);
    run_req(2, 32'h1, 32'd1, 32'h0, lat, st, rd, bok);
    checks++;
    if (lat !== 7 || rd !== 32'h22 || !bok) begin
      errors++;
      $display("FAIL lat7_read: lat=%0d data=%h busy_ok=%0d, want 7/00000022/1", lat, rd, bok);
    end
    ctrl_in[2] = '0;
    @(negedge clk);
  endtask

  task automatic test_drop_busy();
    int lat; logic [31:0] st, rd; bit bok;
    @(negedge clk);
    ctrl_in[0] = 32'h2;
    addr_in[0] = 32'd3;
    din[0]     = 32'hA5A5_A5A5;
    @(negedge clk);
    ctrl_in[0] = '0;
    @(negedge clk);
    checks++;
    if (ctrl_out[0] !== 32'h8) begin
      errors++;
      $display("FAIL drop_busy: ctrl=%h, want 00000008", ctrl_out[0]);
    end
    @(negedge clk);
    checks++;
    if (ctrl_out[0] !== 32'hA) begin
      errors++;
      $display("FAIL drop_pulse_hi: ctrl=%h, want 0000000a", ctrl_out[0]);
    end
    @(negedge clk);
    checks++;
    if (ctrl_out[0] !== 32'h0) begin
      errors++;
      $display("FAIL drop_pulse_lo: ctrl=%h, want 0", ctrl_out[0]);
    end
    run_req(0, 32'h1, 32'd3, 32'h0, lat, st, rd, bok);
    checks++;
    if (rd !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL drop_readback: data=%h, want a5a5a5a5", rd);
    end
    ctrl_in[0] = '0;
    @(negedge clk);
  endtask

  task automatic test_both_pins();
    int lat; logic [31:0] st, rd; bit bok;
    run_req(0, 32'h3, 32'd9, 32'h0F, lat, st, rd, bok);
    checks++;
    if (st !== 32'hA) begin
      errors++;
      $display("FAIL both_write_only: ctrl=%h, want 0000000a", st);
    end
    ctrl_in[0] = '0;
    @(negedge clk);
    run_req(0, 32'h1, 32'd9, 32'h0, lat, st, rd, bok);
    checks++;
    if (rd !== 32'h0F || st !== 32'h9) begin
      errors++;
      $display("FAIL both_readback: ctrl=%h data=%h, want 00000009/0000000f", st, rd);
    end
    ctrl_in[0] = '0;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    int lat; logic [31:0] st, rd; bit bok;
    logic [31:0] exp_st_w, exp_rd0, exp_st_r, exp_rd_hi;
`ifdef RAM_RESPONDER_BOUNDS_CHECK_EN
    exp_st_w = 32'hE; exp_rd0 = 32'h55; exp_st_r = 32'hD; exp_rd_hi = 32'hDEAD_BEEF;
`else
    exp_st_w = 32'hA; exp_rd0 = 32'h77; exp_st_r = 32'h9; exp_rd_hi = 32'h77;
`endif
    run_req(0, 32'h2, 32'd0, 32'h55, lat, st, rd, bok);
    ctrl_in[0] = '0;
    @(negedge clk);
    run_req(0, 32'h2, 32'h400, 32'h77, lat, st, rd, bok);
    checks++;
    if (st !== exp_st_w) begin
      errors++;
      $display("FAIL wrap_write_status: ctrl=%h, want %h", st, exp_st_w);
    end
    ctrl_in[0] = '0;
    @(negedge clk);
    checks++;
    if (ctrl_out[0] !== 32'h0) begin
      errors++;
      $display("FAIL wrap_release: ctrl=%h, want 0", ctrl_out[0]);
    end
    run_req(0, 32'h1, 32'd0, 32'h0, lat, st, rd, bok);
    checks++;
    if (rd !== exp_rd0 || st !== 32'h9) begin
      errors++;
      $display("FAIL wrap_read0: ctrl=%h data=%h, want 00000009/%h", st, rd, exp_rd0);
    end
    ctrl_in[0] = '0;
    @(negedge clk);
    run_req(0, 32'h1, 32'h400, 32'h0, lat, st, rd, bok);
    checks++;
    if (rd !== exp_rd_hi || st !== exp_st_r) begin
      errors++;
      $display("FAIL wrap_read_hi: ctrl=%h data=%h, want %h/%h", st, rd, exp_st_r, exp_rd_hi);
    end
    ctrl_in[0] = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] st, rd; bit bok;
    run_req(0, 32'h2, 32'd2, 32'hBB, lat, st, rd, bok);
    ctrl_in[0] = '0;
    @(negedge clk);
    ctrl_in[0] = 32'h2;
    addr_in[0] = 32'd2;
    din[0]     = 32'hCC;
    @(negedge clk);
    checks++;
    if (ctrl_out[0] !== 32'h8) begin
      errors++;
      $display("FAIL rstmid_busy: ctrl=%h, want 00000008", ctrl_out[0]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (ctrl_out[0] !== 32'h0 || dout[0] !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_async: ctrl=%h data=%h, want 0/0", ctrl_out[0], dout[0]);
    end
    ctrl_in[0] = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ctrl_out[0] !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_idle: ctrl=%h, want 0", ctrl_out[0]);
    end
    run_req(0, 32'h1, 32'd2, 32'h0, lat, st, rd, bok);
    checks++;
    if (rd !== 32'hBB || lat !== 2) begin
      errors++;
      $display("FAIL rstmid_retain: lat=%0d data=%h, want 2/000000bb", lat, rd);
    end
    ctrl_in[0] = '0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_latency();
    test_drop_busy();
    test_both_pins();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
